// File: rtl/gsim_mem_resp.sv
// rtl/gsim_mem_resp.sv - GSIM matrix-read responder with SRAM refresh scheduling and LFSR back-pressure
module gsim_mem_resp #(
    parameter int          SRAM_LAT       = 1,
    parameter int          REFRESH_PERIOD = 256,
    parameter int          REFRESH_LEN    = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_mem_rreq,
    input  logic [9:0]   i_mem_addr,
    output logic         o_mem_rrdy,
    output logic [255:0] o_mem_dout,
    output logic         o_mem_dout_vld,
    input  logic         i_stall_en,
    output logic         o_sram_cen,
    output logic [9:0]   o_sram_addr,
    input  logic [255:0] i_sram_q,
    output logic         o_sram_ref,
    output logic [15:0]  o_rd_cnt
);

    typedef enum logic [1:0] {
        ST_SERVE   = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_REFRESH = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [15:0]    r_lfsr;
    logic [15:0]    w_lfsr_next;
    logic [SRAM_LAT:0] r_vpipe;
    logic [15:0]    r_per_cnt;
    logic [15:0]    r_len_cnt;
    logic           r_rrdy;
    logic           r_cen;
    logic [9:0]     r_addr;
    logic           r_ref;
    logic           r_vld;
    logic [255:0]   r_dout;
    logic [15:0]    r_rd_cnt;
    logic           w_accept;
    logic           w_pipe_clear;
    logic           w_per_hit;
    logic           w_len_hit;

    assign w_accept    = i_mem_rreq && r_rrdy;
    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    // The pipe will be empty after this edge once nothing sits below the capture stage
    // (no new reads can enter while draining).
    assign w_pipe_clear = (r_vpipe[SRAM_LAT-1:0] == '0);
    assign w_per_hit    = (REFRESH_PERIOD != 0) && (r_per_cnt == 16'(REFRESH_PERIOD - 1));
    assign w_len_hit    = (r_len_cnt == 16'(REFRESH_LEN - 1));

    // Next-state decode: SERVE -> DRAIN (or straight to REFRESH when idle) -> REFRESH -> SERVE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SERVE: begin
                if (w_per_hit) begin
                    w_state_next = (!w_accept && w_pipe_clear) ? ST_REFRESH : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pipe_clear) begin
                    w_state_next = ST_REFRESH;
                end
            end
            ST_REFRESH: begin
                if (w_len_hit) begin
                    w_state_next = ST_SERVE;
                end
            end
            default: w_state_next = ST_SERVE;
        endcase
    end

    // Control state: FSM, LFSR, refresh counters and the in-flight valid pipe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_SERVE;
            r_lfsr    <= LFSR_SEED;
            r_vpipe   <= '0;
            r_per_cnt <= '0;
            r_len_cnt <= '0;
            r_rrdy    <= 1'b0;
            r_ref     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_lfsr    <= w_lfsr_next;
            r_vpipe   <= {r_vpipe[SRAM_LAT-1:0], w_accept};
            r_per_cnt <= (r_state == ST_SERVE) ? r_per_cnt + 16'd1 : 16'd0;
            r_len_cnt <= (r_state == ST_REFRESH) ? r_len_cnt + 16'd1 : 16'd0;
            r_rrdy    <= (w_state_next == ST_SERVE) && (!i_stall_en || w_lfsr_next[0]);
            r_ref     <= (w_state_next == ST_REFRESH);
        end
    end

    // Datapath: SRAM launch on acceptance, capture of returning row, request counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cen    <= 1'b0;
            r_addr   <= '0;
            r_vld    <= 1'b0;
            r_dout   <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_cen <= w_accept;
            if (w_accept) begin
                r_addr   <= i_mem_addr;
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            r_vld  <= r_vpipe[SRAM_LAT];
            r_dout <= r_vpipe[SRAM_LAT] ? i_sram_q : '0;
        end
    end

    assign o_mem_rrdy     = r_rrdy;
    assign o_mem_dout     = r_dout;
    assign o_mem_dout_vld = r_vld;
    assign o_sram_cen     = r_cen;
    assign o_sram_addr    = r_addr;
    assign o_sram_ref     = r_ref;
    assign o_rd_cnt       = r_rd_cnt;

endmodule

// File: doc/gsim_mem_resp.md
# gsim_mem_resp

Synthesizable memory responder for the GSIM matrix-read port. It accepts GSIM read requests (rreq/addr/rrdy handshake) and reads 256-bit matrix rows from a single-port SRAM macro. It returns each row in order with a one-cycle `dout_vld` strobe. It also schedules periodic SRAM refresh windows and can inject LFSR-driven back-pressure for silicon stress testing. It sits between the GSIM core and the matrix SRAM, in place of the bench-level memory model.

## Interface
- `SRAM_LAT`, 1: SRAM read latency in cycles; legal range 1..3.
- `REFRESH_PERIOD`, 256: SERVE cycles between refresh windows; 0 disables refresh.
- `REFRESH_LEN`, 4: cycles `o_sram_ref` is held high per window; must be ≥1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_mem_rreq` in 1: read request from GSIM.
- `i_mem_addr` in 10: row address.
- `o_mem_rrdy` out 1: responder ready; registered.
- `o_mem_dout` out 256: row data; 0 whenever `o_mem_dout_vld`=0.
- `o_mem_dout_vld` out 1: one-cycle data strobe.
- `i_stall_en` in 1: enables random back-pressure.
- `o_sram_cen` out 1: SRAM read enable, active high.
- `o_sram_addr` out 10: SRAM address.
- `i_sram_q` in 256: SRAM read data.
- `o_sram_ref` out 1: SRAM refresh command.
- `o_rd_cnt` out 16: accepted-request counter; wraps at 2^16.

## Operation
- **Acceptance:** a request is accepted at rising edge k when `i_mem_rreq`=1 and `o_mem_rrdy`=1 in the preceding cycle. Requests seen while `o_mem_rrdy`=0 are ignored; the initiator holds them.
- **SRAM launch:** at acceptance, register `o_sram_cen`=1 and `o_sram_addr`=`i_mem_addr` for exactly one cycle. `o_rd_cnt` increments by 1.
- **In-flight tracking:** a valid shift register of depth `SRAM_LAT`+1 tracks in-flight reads.
  - Responses return strictly in order.
  - There is no return-path back-pressure, so no FIFO is needed.
- **State machine** (states SERVE, DRAIN, REFRESH):
  - SERVE: the refresh counter increments every cycle. When it reaches `REFRESH_PERIOD`-1 (and `REFRESH_PERIOD`≠0), go to DRAIN.
  - DRAIN: no acceptance. When no read is in flight, go to REFRESH.
  - REFRESH: `o_sram_ref`=1. After `REFRESH_LEN` cycles, go to SERVE and clear the refresh counter.
- **Ready:** `o_mem_rrdy` is registered from the next state and next LFSR value: `rrdy` ← (next==SERVE) && (!`i_stall_en` || `lfsr_next[0]`).
- **LFSR:** 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left every cycle regardless of state or `i_stall_en`.
- **Invariant:** `o_sram_cen` and `o_sram_ref` are never high in the same cycle.
- **Reset:** async assert clears all in-flight reads, counters, and outputs; LFSR loads `LFSR_SEED`; state goes to SERVE.

## Timing
- **Reset values:**
  - `o_mem_rrdy`=0, `o_mem_dout_vld`=0, `o_mem_dout`=0.
  - `o_sram_cen`=0, `o_sram_addr`=0, `o_sram_ref`=0, `o_rd_cnt`=0.
- **First ready:** `o_mem_rrdy` first rises at the first rising edge after `i_rst_n` deasserts, unless stall gating holds it low.
- **Latency:** for a request accepted at edge k:
  - `o_sram_cen` is high in cycle k..k+1.
  - `i_sram_q` is valid after edge k+`SRAM_LAT`.
  - Data is captured at edge k+`SRAM_LAT`+1, so `o_mem_dout_vld`/`o_mem_dout` are valid for one cycle after that edge.
  - Total L=`SRAM_LAT`+1 (default 2).
- **Throughput:** one acceptance per cycle is sustained while `o_mem_rrdy`=1.
- **Entering DRAIN:** `o_mem_rrdy` falls at the edge where next state=DRAIN. A request accepted at that same edge (ready was high the prior cycle) is a legal final read and is drained.
- **DRAIN duration:** DRAIN lasts until the valid pipe is empty: 0 to L cycles. With L=2 and a read in flight, that is 2 cycles.
- **Leaving REFRESH:** `o_mem_rrdy` may rise at the edge entering SERVE.
- **Mid-operation reset:** in-flight reads are dropped. No `o_mem_dout_vld` is issued for them after release.
- **Stall toggling:** changing `i_stall_en` takes effect on `o_mem_rrdy` at the next edge.

## Test plan
1. **Single read:** stall off; SRAM model row 5 = {8{32'hDEADBEEF}}; one-cycle rreq with addr 5.
   - `o_sram_cen` is high one cycle with addr 5.
   - `o_mem_dout_vld` is high exactly one cycle, 2 edges after acceptance, with that data.
   - `o_mem_dout`=0 otherwise; `o_rd_cnt`=1.
2. **Streaming:** continuous rreq with addr 0..15, refresh disabled.
   - 16 consecutive vld cycles, in address order, with no gaps.
3. **Refresh:** `REFRESH_PERIOD`=16, `REFRESH_LEN`=4, continuous rreq.
   - `o_mem_rrdy` is low for DRAIN plus 4 cycles.
   - `o_sram_ref` is high exactly 4 cycles, never overlapping `o_sram_cen`.
   - Vld count equals acceptance count; no data lost.
4. **Stall:** `i_stall_en`=1, seed 16'hACE1, continuous rreq.
   - `o_mem_rrdy` matches a bench LFSR model bit-for-bit.
   - Vld pulses equal `o_rd_cnt` after draining.
5. **Reset mid-operation:** assert `i_rst_n`=0 with 2 reads in flight.
   - All outputs are 0 immediately.
   - No vld after release.
   - `o_mem_rrdy`=1 at the first edge after release.
6. **SRAM_LAT=3 build:** a single read returns vld 4 edges after acceptance; a DRAIN with a read in flight lasts 4 cycles.
